// File: rtl/codec_i2c_responder.sv
// codec_i2c_responder: write-only I2C target that loads 9-bit codec registers into a 16-entry file
// Ports: clk/rst_n system clock and async active-low reset; scl/sda_in raw bus inputs;
// sda_pull open-drain low drive; reg_valid/reg_addr/reg_data last committed write;
// rd_addr/rd_data combinational regfile readback; busy between START and STOP;
// frame_err pulse on a truncated transaction.
module codec_i2c_responder #(
  parameter logic [6:0] DEV_ADDR = 7'h1A,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       scl,
  input  logic       sda_in,
  output logic       sda_pull,
  output logic       reg_valid,
  output logic [6:0] reg_addr,
  output logic [8:0] reg_data,
  input  logic [3:0] rd_addr,
  output logic [8:0] rd_data,
  output logic       busy,
  output logic       frame_err
);
  typedef enum logic [2:0] {IDLE, DEV, ACK_DEV, BYTE1, ACK1, BYTE2, ACK2, IGNORE} state_t;
  state_t state, state_n;
  logic [SYNC_STAGES-1:0] scl_sr, sda_sr;
  logic scl_p, sda_p, scl_s, sda_s;
  logic start, stop, scl_rise, scl_fall;
  logic [2:0] cnt, cnt_n;
  logic [6:0] sh, sh_n;
  logic [7:0] b1, b1_n, byte_in;
  logic pull_n, commit, ferr_n;
  logic [8:0] regs [16];
  // Synchronisers reset to the idle-bus level so reset release never looks like an edge
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      scl_sr <= '1;
      sda_sr <= '1;
      scl_p  <= 1'b1;
      sda_p  <= 1'b1;
    end else begin
      scl_sr <= {scl_sr[SYNC_STAGES-2:0], scl};
      sda_sr <= {sda_sr[SYNC_STAGES-2:0], sda_in};
      scl_p  <= scl_s;
      sda_p  <= sda_s;
    end
  assign scl_s    = scl_sr[SYNC_STAGES-1];
  assign sda_s    = sda_sr[SYNC_STAGES-1];
  assign start    = scl_s & scl_p & sda_p & ~sda_s;
  assign stop     = scl_s & scl_p & ~sda_p & sda_s;
  assign scl_rise = scl_s & ~scl_p;
  assign scl_fall = ~scl_s & scl_p;
  assign byte_in  = {sh, sda_s};
  assign busy     = state != IDLE;
  assign rd_data  = regs[rd_addr];
  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    sh_n    = sh;
    b1_n    = b1;
    pull_n  = sda_pull;
    commit  = 1'b0;
    ferr_n  = 1'b0;
    if (start || stop) begin
      state_n = start ? DEV : IDLE;
      cnt_n   = 3'd0;
      pull_n  = 1'b0;
      ferr_n  = state inside {BYTE1, ACK1, BYTE2} || (state == DEV && cnt != 3'd0);
    end else if (state inside {DEV, BYTE1, BYTE2} && scl_rise) begin
      sh_n  = byte_in[6:0];
      cnt_n = cnt + 3'd1;
      if (cnt == 3'd7) begin
        state_n = state == DEV ? ((byte_in[7:1] == DEV_ADDR && !byte_in[0]) ? ACK_DEV : IGNORE)
                : state == BYTE1 ? ACK1 : ACK2;
        b1_n    = state == BYTE1 ? byte_in : b1;
        commit  = state == BYTE2;
      end
    end else if (state inside {ACK_DEV, ACK1, ACK2} && scl_fall) begin
      // First falling edge in an ACK state grabs sda, the next one lets go and moves on
      pull_n  = !sda_pull;
      state_n = !sda_pull ? state : state == ACK_DEV ? BYTE1 : state == ACK1 ? BYTE2 : IGNORE;
    end
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      sh        <= '0;
      b1        <= '0;
      sda_pull  <= 1'b0;
      reg_valid <= 1'b0;
      frame_err <= 1'b0;
      reg_addr  <= '0;
      reg_data  <= '0;
    end else begin
      state     <= state_n;
      cnt       <= cnt_n;
      sh        <= sh_n;
      b1        <= b1_n;
      sda_pull  <= pull_n;
      reg_valid <= commit;
      frame_err <= ferr_n;
      if (commit) begin
        reg_addr <= b1[7:1];
        reg_data <= {b1[0], byte_in};
      end
    end
  // Register 0x0F acts as a reset command for the whole file
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      for (int i = 0; i < 16; i++) regs[i] <= '0;
    end else if (reg_valid) begin
      if (reg_addr == 7'h0F) for (int i = 0; i < 16; i++) regs[i] <= '0;
      else if (reg_addr < 7'h0F) regs[reg_addr[3:0]] <= reg_data;
    end
endmodule
